// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity encodings, FSM states and
// the baud divider helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for rxd plus the sample-point bit.
// UART_RX_MAJORITY_EN: bit is the 2-of-3 vote around the sample point.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxs,
  output logic smp
);

`ifdef UART_RX_MAJORITY_EN
  logic s1, s2, s3, s4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {s4, s3, s2, s1} <= 4'hF;
    else        {s4, s3, s2, s1} <= {s3, s2, s1, rxd};
  end

  // FSM runs one cycle behind, so s2/s3/s4 are the values after/at/before
  // its nominal sample point.
  assign rxs = s3;
  assign smp = (s2 & s3) | (s2 & s4) | (s3 & s4);
`else
  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {s2, s1} <= 2'b11;
    else        {s2, s1} <= {s1, rxd};
  end

  assign rxs = s2;
  assign smp = s2;
`endif

endmodule

// File: rtl/uart_rx.sv
// Parametrised UART receiver: start/data/parity/stop framing with false-start
// rejection and break recovery. Optional macro: UART_RX_MAJORITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9_600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV  = calc_div(CLK_HZ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_END = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_END = BW'(DATA_BITS - 1);
  localparam logic          STP_END = 1'(STOP_BITS - 1);

  if (DIV < 4) begin : g_bad_div
    $error("uart_rx: CLK_HZ/BAUD must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx: STOP_BITS must be 1 or 2");
  end

  logic rxs, smp;

  uart_rx_sampler u_smp (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rxs   (rxs),
    .smp   (smp)
  );

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bcnt;
  logic                 scnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, fe_acc;

  wire tick = (cnt == CNT_END);
  wire mid  = (cnt == CNT_MID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      scnt       <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      fe_acc     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: if (!rxs) begin
          cnt     <= '0;
          bcnt    <= '0;
          scnt    <= 1'b0;
          par_acc <= 1'b0;
          fe_acc  <= 1'b0;
          state   <= S_START;
          busy    <= 1'b1;
        end
        S_START: if (mid) begin
          cnt <= '0;
          // high at mid-start is a glitch, not a frame
          if (smp) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_DATA;
          end
        end else cnt <= cnt + 1'b1;
        S_DATA: if (tick) begin
          cnt   <= '0;
          shreg <= {smp, shreg[DATA_BITS-1:1]};
          bcnt  <= bcnt + 1'b1;
          if (bcnt == BIT_END) state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end else cnt <= cnt + 1'b1;
        S_PARITY: if (tick) begin
          cnt     <= '0;
          par_acc <= ((^shreg) ^ smp) != (PARITY == PAR_ODD);
          state   <= S_STOP;
        end else cnt <= cnt + 1'b1;
        S_STOP: if (tick) begin
          cnt <= '0;
          if (scnt == STP_END) begin
            rx_data    <= shreg;
            parity_err <= par_acc;
            frame_err  <= fe_acc | ~smp;
            rx_valid   <= 1'b1;
            if (smp) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_BREAK;
            end
          end else begin
            fe_acc <= fe_acc | ~smp;
            scnt   <= 1'b1;
          end
        end else cnt <= cnt + 1'b1;
        S_BREAK: if (rxs) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
